// File: rtl/pe_sched.sv
// pe_sched: fetches beat-count instructions and streams SRAM addresses plus PE valid/ctl, then buffers PE results.
// Optional performance counters are built only when PE_SCHED_PERF_EN is defined.
module pe_sched #(
    parameter int INST_AW = 4,
    parameter int DATA_AW = 16,
    parameter int RES_AW  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [INST_AW:0]   inst_num,
    input  logic               hold,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               inst_rd_en,
    output logic [INST_AW-1:0] inst_addr,
    input  logic [7:0]         inst_data,
    output logic               data_rd_en,
    output logic [DATA_AW-1:0] data_addr,
    output logic               pe_vld_i,
    output logic [1:0]         pe_ctl,
    input  logic               pe_vld_o,
    input  logic [31:0]        pe_result,
    output logic               res_wr_en,
    output logic [RES_AW-1:0]  res_addr,
    output logic [31:0]        res_data,
    output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_beats
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_DRAIN, S_DONE} state_t;
    state_t state_reg, state_next;

    logic [INST_AW:0]   inst_num_reg;
    logic [INST_AW-1:0] inst_addr_reg;
    logic [DATA_AW-1:0] data_addr_reg;
    logic [RES_AW-1:0]  res_addr_reg;
    logic [INST_AW:0]   issued_cnt_reg;
    logic [INST_AW:0]   res_cnt_reg;
    logic [7:0]         len_reg;
    logic [7:0]         beat_reg;
    logic               err_reg;
    logic               pe_vld_i_reg;
    logic [1:0]         pe_ctl_reg;
    logic               res_wr_en_reg;
    logic [31:0]        res_data_reg;

    logic accept, run_start, issue_beat, last_beat, inst_end, skip_inst, last_inst, capture;

    assign last_inst = ({1'b0, inst_addr_reg} == inst_num_reg - (INST_AW+1)'(1));
    assign last_beat = (beat_reg == len_reg - 8'd1);
    assign capture   = pe_vld_o && (state_reg != S_IDLE);
    assign run_start = accept && (inst_num != '0);

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        issue_beat = 1'b0;
        inst_end   = 1'b0;
        skip_inst  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (inst_num == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                if (inst_data == 8'd0) begin
                    skip_inst  = 1'b1;
                    state_next = last_inst ? S_DRAIN : S_FETCH;
                end else begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!hold) begin
                    issue_beat = 1'b1;
                    if (last_beat) begin
                        inst_end   = 1'b1;
                        state_next = last_inst ? S_DRAIN : S_FETCH;
                    end
                end
            end
            // Result counter is registered, so completion lands the cycle after the final write.
            S_DRAIN: if (res_cnt_reg == issued_cnt_reg) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_num_reg   <= '0;
            inst_addr_reg  <= '0;
            data_addr_reg  <= '0;
            res_addr_reg   <= '0;
            issued_cnt_reg <= '0;
            res_cnt_reg    <= '0;
            len_reg        <= '0;
            beat_reg       <= '0;
            err_reg        <= 1'b0;
            pe_vld_i_reg   <= 1'b0;
            pe_ctl_reg     <= 2'b00;
            res_wr_en_reg  <= 1'b0;
            res_data_reg   <= '0;
        end else begin
            // Beat strobes are delayed one cycle to line up with SRAM read data.
            pe_vld_i_reg  <= issue_beat;
            pe_ctl_reg    <= issue_beat ? {last_beat, beat_reg == 8'd0} : 2'b00;
            res_wr_en_reg <= capture;
            if (capture) res_data_reg <= pe_result;

            if (accept) begin
                inst_num_reg <= inst_num;
                err_reg      <= 1'b0;
            end else if (skip_inst) begin
                err_reg <= 1'b1;
            end

            if (run_start) begin
                inst_addr_reg  <= '0;
                data_addr_reg  <= '0;
                issued_cnt_reg <= '0;
            end else begin
                if (skip_inst || inst_end) inst_addr_reg <= inst_addr_reg + INST_AW'(1);
                if (issue_beat)            data_addr_reg <= data_addr_reg + DATA_AW'(1);
                if (inst_end)              issued_cnt_reg <= issued_cnt_reg + (INST_AW+1)'(1);
            end

            if (state_reg == S_DECODE) begin
                len_reg  <= inst_data;
                beat_reg <= 8'd0;
            end else if (issue_beat) begin
                beat_reg <= beat_reg + 8'd1;
            end

            if (run_start) begin
                res_addr_reg <= '0;
                res_cnt_reg  <= '0;
            end else begin
                if (res_wr_en_reg) res_addr_reg <= res_addr_reg + RES_AW'(1);
                if (capture)       res_cnt_reg  <= res_cnt_reg + (INST_AW+1)'(1);
            end
        end
    end

`ifdef PE_SCHED_PERF_EN
    logic [31:0] perf_cycles_reg;
    logic [31:0] perf_beats_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_reg <= '0;
            perf_beats_reg  <= '0;
        end else if (accept) begin
            perf_cycles_reg <= '0;
            perf_beats_reg  <= '0;
        end else begin
            if (state_reg != S_IDLE) perf_cycles_reg <= perf_cycles_reg + 32'd1;
            if (issue_beat)          perf_beats_reg  <= perf_beats_reg + 32'd1;
        end
    end

    assign perf_cycles = perf_cycles_reg;
    assign perf_beats  = perf_beats_reg;
`else
    assign perf_cycles = 32'd0;
    assign perf_beats  = 32'd0;
`endif

    assign busy       = (state_reg != S_IDLE);
    assign done       = (state_reg == S_DONE);
    assign err        = err_reg;
    assign inst_rd_en = (state_reg == S_FETCH);
    assign inst_addr  = inst_addr_reg;
    assign data_rd_en = issue_beat;
    assign data_addr  = data_addr_reg;
    assign pe_vld_i   = pe_vld_i_reg;
    assign pe_ctl     = pe_ctl_reg;
    assign res_wr_en  = res_wr_en_reg;
    assign res_addr   = res_addr_reg;
    assign res_data   = res_data_reg;
endmodule

// File: tb/tb_pe_sched.sv
// Bench for pe_sched: instruction SRAM, data SRAM returning its address, and an accumulating PE model.
module tb_pe_sched;
    localparam int INST_AW = 4;
    localparam int DATA_AW = 16;
    localparam int RES_AW  = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [INST_AW:0]   inst_num = '0;
    logic               hold = 1'b0;
    logic               busy, done, err, inst_rd_en, data_rd_en, pe_vld_i, res_wr_en;
    logic [INST_AW-1:0] inst_addr;
    logic [7:0]         inst_data;
    logic [DATA_AW-1:0] data_addr;
    logic [1:0]         pe_ctl;
    logic               pe_vld_o;
    logic [31:0]        pe_result, res_data, perf_cycles, perf_beats;
    logic [RES_AW-1:0]  res_addr;

    logic [7:0]  inst_mem [16];
    logic [31:0] rd_data;
    logic [31:0] acc;
    logic [31:0] acc_nxt;

    always #5 clk = ~clk;

    pe_sched #(.INST_AW(INST_AW), .DATA_AW(DATA_AW), .RES_AW(RES_AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inst_num(inst_num), .hold(hold),
        .busy(busy), .done(done), .err(err),
        .inst_rd_en(inst_rd_en), .inst_addr(inst_addr), .inst_data(inst_data),
        .data_rd_en(data_rd_en), .data_addr(data_addr),
        .pe_vld_i(pe_vld_i), .pe_ctl(pe_ctl), .pe_vld_o(pe_vld_o), .pe_result(pe_result),
        .res_wr_en(res_wr_en), .res_addr(res_addr), .res_data(res_data),
        .perf_cycles(perf_cycles), .perf_beats(perf_beats)
    );

    always_ff @(posedge clk) begin
        if (inst_rd_en) inst_data <= inst_mem[inst_addr];
        if (data_rd_en) rd_data <= {16'd0, data_addr};
    end

    assign acc_nxt = (pe_ctl[0] ? 32'd0 : acc) + rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            pe_vld_o  <= 1'b0;
            pe_result <= '0;
        end else begin
            pe_vld_o <= pe_vld_i && pe_ctl[1];
            if (pe_vld_i) begin
                acc <= acc_nxt;
                if (pe_ctl[1]) pe_result <= acc_nxt;
            end
        end
    end

    typedef struct {
        string      name;
        int         n;
        logic [7:0] i0, i1, i2, i3;
        int         hold_at, hold_len;
        int         beats, c0, c1, writes;
        logic       err;
        int         done_cyc, gap_bad, inst_rd, fv_cyc;
        logic [1:0] fctl;
    } vec_t;

    vec_t tbl [5];

    int n_vec = 0;
    int n_bad = 0;

    int k, hold_at, hold_len;
    int beats, c0, c1, writes, inst_rd, done_cnt, done_cyc;
    int busy_bad, gap_bad, align_bad, addr_bad, hold_viol, fv_cyc, last_beat_cyc;
    logic [1:0]         fctl;
    logic               prev_rd, err_at_done;
    logic [DATA_AW-1:0] exp_addr;
    logic [RES_AW-1:0]  wr_addr [16];
    logic [31:0]        wr_data [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        start = 1'b0;
        k++;
        hold = (k >= hold_at) && (k < hold_at + hold_len);
        @(negedge clk);
        if (hold && data_rd_en) hold_viol++;
        if (!busy && done_cnt == 0) busy_bad++;
        if (inst_rd_en) inst_rd++;
        if (data_rd_en) begin
            if (data_addr !== exp_addr) addr_bad++;
            exp_addr++;
            if (!prev_rd && last_beat_cyc >= 0 && (k - last_beat_cyc - 1) != 2) gap_bad++;
            last_beat_cyc = k;
            beats++;
        end
        if (pe_vld_i !== prev_rd) align_bad++;
        if (pe_vld_i) begin
            if (fv_cyc == 0) begin
                fv_cyc = k;
                fctl = pe_ctl;
            end
            if (pe_ctl[0]) c0++;
            if (pe_ctl[1]) c1++;
        end
        if (res_wr_en) begin
            if (writes < 16) begin
                wr_addr[writes] = res_addr;
                wr_data[writes] = res_data;
            end
            writes++;
        end
        if (done) begin
            done_cnt++;
            if (done_cyc == 0) begin
                done_cyc = k;
                err_at_done = err;
            end
        end
        prev_rd = data_rd_en;
    endtask

    // abort_at != 0 stops the run at that cycle without checking anything.
    task automatic run_scn(input vec_t v, input int abort_at);
        logic [7:0]  ls [4];
        logic [31:0] exp_sum [4];
        int          ne, base;
        ls[0] = v.i0; ls[1] = v.i1; ls[2] = v.i2; ls[3] = v.i3;
        for (int i = 0; i < 16; i++) inst_mem[i] = 8'd0;
        for (int i = 0; i < 4; i++) inst_mem[i] = ls[i];
        ne = 0;
        base = 0;
        for (int j = 0; j < v.n; j++) begin
            if (ls[j] != 8'd0) begin
                exp_sum[ne] = 0;
                for (int a = base; a < base + int'(ls[j]); a++) exp_sum[ne] += 32'(a);
                base += int'(ls[j]);
                ne++;
            end
        end
        k = 0; hold_at = v.hold_at; hold_len = v.hold_len;
        beats = 0; c0 = 0; c1 = 0; writes = 0; inst_rd = 0; done_cnt = 0; done_cyc = 0;
        busy_bad = 0; gap_bad = 0; align_bad = 0; addr_bad = 0; hold_viol = 0;
        fv_cyc = 0; fctl = 2'b00; last_beat_cyc = -1; prev_rd = 1'b0; err_at_done = 1'b0;
        exp_addr = '0;

        @(posedge clk);
        #1;
        start = 1'b1;
        inst_num = (INST_AW+1)'(v.n);
        @(negedge clk);
        while (done_cnt == 0 && k < 600) begin
            cyc();
            if (abort_at != 0 && k == abort_at) return;
        end
        chk({v.name, ".done_seen"}, done_cnt, 1);
        cyc();
        chk({v.name, ".done_pulses"}, done_cnt, 1);
        chk({v.name, ".busy_after"}, {31'd0, busy}, 0);
        chk({v.name, ".done_cyc"}, done_cyc, v.done_cyc);
        chk({v.name, ".beats"}, beats, v.beats);
        chk({v.name, ".first_beats"}, c0, v.c0);
        chk({v.name, ".last_beats"}, c1, v.c1);
        chk({v.name, ".writes"}, writes, v.writes);
        chk({v.name, ".err"}, {31'd0, err_at_done}, {31'd0, v.err});
        chk({v.name, ".gaps"}, gap_bad, v.gap_bad);
        chk({v.name, ".inst_reads"}, inst_rd, v.inst_rd);
        chk({v.name, ".first_vld_cyc"}, fv_cyc, v.fv_cyc);
        chk({v.name, ".first_ctl"}, {30'd0, fctl}, {30'd0, v.fctl});
        chk({v.name, ".vld_align"}, align_bad, 0);
        chk({v.name, ".addr_seq"}, addr_bad, 0);
        chk({v.name, ".hold_beats"}, hold_viol, 0);
        chk({v.name, ".busy_span"}, busy_bad, 0);
        for (int j = 0; j < ne && j < writes; j++) begin
            chk($sformatf("%s.res_addr%0d", v.name, j), {28'd0, wr_addr[j]}, 32'(j));
            chk($sformatf("%s.res_data%0d", v.name, j), wr_data[j], exp_sum[j]);
        end
`ifdef PE_SCHED_PERF_EN
        chk({v.name, ".perf_beats"}, perf_beats, 32'(v.beats));
        chk({v.name, ".perf_cycles"}, perf_cycles, 32'(v.done_cyc));
`endif
    endtask

    function automatic logic any_out();
        return |{busy, done, err, inst_rd_en, inst_addr, data_rd_en, data_addr, pe_vld_i, pe_ctl,
                 res_wr_en, res_addr, res_data, perf_cycles, perf_beats};
    endfunction

    initial begin
        //          name      n  i0     i1     i2     i3     hat hlen beats c0 c1 wr err  done gap ird fv fctl
        tbl[0] = '{"quad35", 4, 8'd35, 8'd35, 8'd35, 8'd35, 0,  0,  140,  4, 4, 4, 1'b0, 152, 0,  4,  4, 2'b01};
        tbl[1] = '{"single", 1, 8'd1,  8'd0,  8'd0,  8'd0,  0,  0,  1,    1, 1, 1, 1'b0, 7,   0,  1,  4, 2'b11};
        tbl[2] = '{"hold5",  4, 8'd35, 8'd35, 8'd35, 8'd35, 10, 5,  140,  4, 4, 4, 1'b0, 157, 1,  4,  4, 2'b01};
        tbl[3] = '{"empty",  0, 8'd0,  8'd0,  8'd0,  8'd0,  0,  0,  0,    0, 0, 0, 1'b0, 1,   0,  0,  0, 2'b00};
        tbl[4] = '{"zerolen",3, 8'd3,  8'd0,  8'd2,  8'd0,  0,  0,  5,    2, 2, 2, 1'b1, 15,  1,  3,  4, 2'b01};

        repeat (2) @(negedge clk);
        chk("reset_outs", {31'd0, any_out()}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 5; t++) run_scn(tbl[t], 0);

        // Reset in the middle of an instruction, then an identical clean rerun.
        run_scn(tbl[0], 20);
        rst_n = 1'b0;
        hold = 1'b0;
        #1;
        chk("midrun_reset_outs", {31'd0, any_out()}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("held_reset_outs", {31'd0, any_out()}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_scn(tbl[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
